// File: rtl/memaccess.sv
// Venus memory-access stage: drives the synchronous data memory and presents a registered writeback slot.
// Optional MEMACCESS_PERF_EN adds accepted-load/store counters (ld_cnt_o, st_cnt_o).
module memaccess #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  output logic              stall_o,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] result_i,
  input  logic [WORD_W-1:0] sdata_i,
  input  logic              wb_i,
  input  logic [RD_W-1:0]   rd_num_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_d_o,
  input  logic [WORD_W-1:0] mem_q_i,
  output logic              v_o,
  input  logic              stall_i,
  output logic              wb_o,
  output logic [RD_W-1:0]   rd_num_o,
  output logic [WORD_W-1:0] rd_data_o
`ifdef MEMACCESS_PERF_EN
  ,
  output logic [31:0]       ld_cnt_o,
  output logic [31:0]       st_cnt_o
`endif
);

  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;

  logic              accept;
  logic              is_ld;
  logic              is_st;
  logic              v_q, v_d;
  logic              wb_q, wb_d;
  logic              ld_q, ld_d;
  logic              cap_q, cap_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [WORD_W-1:0] data_q, data_d;

  assign stall_o    = v_q & stall_i;
  assign accept     = v_i & ~stall_o;
  assign is_ld      = (op_i == OP_LD);
  assign is_st      = (op_i == OP_ST);

  assign mem_addr_o = addr_i;
  assign mem_we_o   = accept & is_st;
  assign mem_d_o    = sdata_i;

  // Load data flows straight from memory until captured on the first stalled edge.
  assign rd_data_o  = (ld_q & ~cap_q) ? mem_q_i : data_q;
  assign v_o        = v_q;
  assign wb_o       = wb_q & v_q;
  assign rd_num_o   = rd_q;

  always_comb begin
    v_d    = v_q;
    wb_d   = wb_q;
    ld_d   = ld_q;
    cap_d  = cap_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (accept) begin
      v_d    = 1'b1;
      wb_d   = wb_i & ~is_st;
      rd_d   = rd_num_i;
      data_d = result_i;
      ld_d   = is_ld;
      cap_d  = 1'b0;
    end else if (!stall_i) begin
      v_d  = 1'b0;
      wb_d = 1'b0;
    end else if (v_q && ld_q && !cap_q) begin
      data_d = mem_q_i;
      cap_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      wb_q   <= 1'b0;
      ld_q   <= 1'b0;
      cap_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      wb_q   <= wb_d;
      ld_q   <= ld_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

`ifdef MEMACCESS_PERF_EN
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;

  assign ld_cnt_d = ld_cnt_q + 32'(accept & is_ld);
  assign st_cnt_d = st_cnt_q + 32'(accept & is_st);
  assign ld_cnt_o = ld_cnt_q;
  assign st_cnt_o = st_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_memaccess.sv
// Testbench for memaccess: synchronous memory model plus a scoreboard of expected writeback slots.
// Define MEMACCESS_PERF_EN to also exercise the load/store counters.
module tb_memaccess;

  logic        clk, rst;
  logic        v_i, stall_o, wb_i, mem_we_o, v_o, stall_i, wb_o;
  logic [1:0]  op_i;
  logic [15:0] addr_i, mem_addr_o;
  logic [31:0] result_i, sdata_i, mem_d_o, mem_q_i, rd_data_o;
  logic [4:0]  rd_num_i, rd_num_o;
`ifdef MEMACCESS_PERF_EN
  logic [31:0] ld_cnt_o, st_cnt_o;
`endif

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_mem [logic [15:0]];
  logic [31:0] mem [0:65535];
  logic        garbage;
  int          checks = 0;
  int          errors = 0;

  memaccess dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .op_i(op_i),
    .addr_i(addr_i), .result_i(result_i), .sdata_i(sdata_i), .wb_i(wb_i),
    .rd_num_i(rd_num_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_d_o(mem_d_o), .mem_q_i(mem_q_i), .v_o(v_o), .stall_i(stall_i),
    .wb_o(wb_o), .rd_num_o(rd_num_o), .rd_data_o(rd_data_o)
`ifdef MEMACCESS_PERF_EN
    , .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, one-cycle read latency; garbage mode scrambles read data.
  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_d_o;
    mem_q_i <= garbage ? $urandom : mem[mem_addr_o];
  end

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
  endfunction

  task automatic drive_op(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] res,
                          input logic [31:0] sd, input logic wb, input logic [4:0] rd);
    exp_t e;
    v_i = 1'b1; op_i = op; addr_i = addr; result_i = res; sdata_i = sd; wb_i = wb; rd_num_i = rd;
    e.wb   = wb & (op != 2'b10);
    e.rd   = rd;
    e.data = (op == 2'b01) ? mem_rd(addr) : res;
    if (op == 2'b10) exp_mem[addr] = sd;
    sbq.push_back(e);
  endtask

  task automatic idle();
    v_i = 1'b0; op_i = 2'b00; addr_i = '0; result_i = '0; sdata_i = '0; wb_i = 1'b0; rd_num_i = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({v_o, wb_o, rd_num_o, rd_data_o, stall_o} !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {v_o, wb_o, rd_num_o, rd_data_o, stall_o});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    exp_t e;
    @(negedge clk);
    drive_op(2'b00, 16'h0, 32'h12345678, 32'h0, 1'b1, 5'd7);
    @(negedge clk);
    idle();
    checks++;
    if ({v_o, wb_o, rd_num_o, rd_data_o} !== {1'b1, 1'b1, 5'd7, 32'h12345678}) begin
      errors++;
      $display("FAIL passthrough got %h want %h", {v_o, wb_o, rd_num_o, rd_data_o},
               {1'b1, 1'b1, 5'd7, 32'h12345678});
    end
    e = sbq.pop_front();
    @(negedge clk);
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_drain v_o got %b want 0", v_o);
    end
  endtask

  task automatic test_store_load();
    exp_t e;
    @(negedge clk);
    drive_op(2'b10, 16'h0040, 32'h00000111, 32'hDEADBEEF, 1'b1, 5'd4);
    #1;
    checks++;
    if (mem_we_o !== 1'b1) begin
      errors++;
      $display("FAIL store_we got %b want 1", mem_we_o);
    end
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if ({v_o, wb_o, rd_num_o, rd_data_o} !== {1'b1, e.wb, e.rd, e.data}) begin
      errors++;
      $display("FAIL store_slot got %h want %h", {v_o, wb_o, rd_num_o, rd_data_o}, {1'b1, e.wb, e.rd, e.data});
    end
    drive_op(2'b01, 16'h0040, 32'h00000222, 32'h0, 1'b1, 5'd3);
    @(negedge clk);
    idle();
    e = sbq.pop_front();
    checks++;
    if ({v_o, wb_o, rd_num_o, rd_data_o} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL load_after_store got %h want %h", {v_o, wb_o, rd_num_o, rd_data_o},
               {1'b1, 1'b1, 5'd3, 32'hDEADBEEF});
    end
    @(negedge clk);
  endtask

  task automatic test_stall_capture();
    exp_t e;
    mem[16'h0010]     = 32'hCAFEF00D;
    exp_mem[16'h0010] = 32'hCAFEF00D;
    @(negedge clk);
    drive_op(2'b01, 16'h0010, 32'h0, 32'h0, 1'b1, 5'd9);
    @(negedge clk);
    e = sbq.pop_front();
    stall_i = 1'b1;
    garbage = 1'b1;
    drive_op(2'b10, 16'h0020, 32'h00000333, 32'h5555AAAA, 1'b0, 5'd2);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) stall_i = 1'b0;
      #1;
      checks++;
      if ({v_o, wb_o, rd_num_o, rd_data_o} !== {1'b1, e.wb, e.rd, e.data}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %h want %h", c, {v_o, wb_o, rd_num_o, rd_data_o},
                 {1'b1, e.wb, e.rd, e.data});
      end
      checks++;
      if ({stall_o, mem_we_o} !== {(c < 3), (c == 3)}) begin
        errors++;
        $display("FAIL stall_ctrl[%0d] got stall/we %b want %b", c, {stall_o, mem_we_o}, {(c < 3), (c == 3)});
      end
    end
    @(negedge clk);
    idle();
    garbage = 1'b0;
    e = sbq.pop_front();
    checks++;
    if ({v_o, wb_o, rd_num_o, rd_data_o} !== {1'b1, e.wb, e.rd, e.data}) begin
      errors++;
      $display("FAIL post_stall_store got %h want %h", {v_o, wb_o, rd_num_o, rd_data_o}, {1'b1, e.wb, e.rd, e.data});
    end
    @(negedge clk);
    checks++;
    if (v_o !== 1'b0) begin
      errors++;
      $display("FAIL post_stall_drain v_o got %b want 0", v_o);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    drive_op(2'b01, 16'h0040, 32'h0, 32'h0, 1'b1, 5'd6);
    @(negedge clk);
    idle();
    stall_i = 1'b1;
    e = sbq.pop_front();
    #1;
    checks++;
    if ({v_o, rd_data_o} !== {1'b1, e.data}) begin
      errors++;
      $display("FAIL midrst_pre got %h want %h", {v_o, rd_data_o}, {1'b1, e.data});
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({v_o, wb_o, rd_num_o, rd_data_o, stall_o} !== 40'h0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0", {v_o, wb_o, rd_num_o, rd_data_o, stall_o});
    end
    @(negedge clk);
    rst = 1'b0;
    stall_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({v_o, rd_data_o} !== 33'h0) begin
      errors++;
      $display("FAIL midrst_after got %h want 0", {v_o, rd_data_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops   [8] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    logic [15:0] addrs [8] = '{16'h0040, 16'h0050, 16'h0, 16'h0050, 16'h0060, 16'h0, 16'h0060, 16'h0070};
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (v_o !== ((i >= 1) && (i <= 8))) begin
        errors++;
        $display("FAIL b2b_valid[%0d] got %b want %b", i, v_o, ((i >= 1) && (i <= 8)));
      end
      if (v_o === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({wb_o, rd_num_o, rd_data_o} !== {e.wb, e.rd, e.data}) begin
          errors++;
          $display("FAIL b2b_slot[%0d] got %h want %h", i, {wb_o, rd_num_o, rd_data_o}, {e.wb, e.rd, e.data});
        end
      end
      if (i < 8)
        drive_op(ops[i], addrs[i], 32'h1000 + 32'(i), 32'hA000_0000 + 32'(i), 1'b1, 5'(i + 10));
      else
        idle();
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL b2b_leftover got %0d want 0", sbq.size());
    end
`ifdef MEMACCESS_PERF_EN
    checks++;
    if ({ld_cnt_o, st_cnt_o} !== {32'd3, 32'd3}) begin
      errors++;
      $display("FAIL perf_counts got ld %0d st %0d want 3 3", ld_cnt_o, st_cnt_o);
    end
`endif
  endtask

`ifdef MEMACCESS_PERF_EN
  task automatic test_perf_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ld_cnt_o, st_cnt_o} !== 64'h0) begin
      errors++;
      $display("FAIL perf_reset got ld %0d st %0d want 0 0", ld_cnt_o, st_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    garbage = 1'b0;
    idle();
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
    test_reset();
    test_passthrough();
    test_store_load();
    test_stall_capture();
    test_reset_mid();
    test_back_to_back();
`ifdef MEMACCESS_PERF_EN
    test_perf_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
